// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control logic.
// - state_t : interlock controller FSM encoding (RUN, RAW_STALL, MDU_WAIT, REDIRECT)
// - OP_*    : primary opcodes of the instruction classes the decoder feeds us
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RAW_STALL = 2'd1,
    ST_MDU_WAIT  = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the GPR file.
// One down-counter per register holds how many stages remain until the
// register file is written; non-zero means the value is not yet readable.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   issue, issue_reg    load cnt[issue_reg] with WB_DEPTH this cycle
//   hold                freeze all counters (pipe frozen behind the MDU)
//   rs, rt              read-port indices
//   busy_rs, busy_rt    read-port results: counter non-zero
//   any_busy            any counter non-zero
module reg_scoreboard #(
  parameter int NREG     = 32,
  parameter int REGW     = 5,
  parameter int WB_DEPTH = 3,
  parameter int CNT_W    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue,
  input  logic [REGW-1:0] issue_reg,
  input  logic            hold,
  input  logic [REGW-1:0] rs,
  input  logic [REGW-1:0] rt,
  output logic            busy_rs,
  output logic            busy_rt,
  output logic            any_busy
);

  logic [CNT_W-1:0] cnt [NREG];

  // NOTE: this array is pipeline state, not storage: a stale count after reset
  // would stall decode on a phantom write, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;  // $zero is never pending
      for (int i = 1; i < NREG; i++) begin
        // A fresh issue outranks the decrement of an older write to the same register.
        if (issue && (issue_reg == REGW'(i)))
          cnt[i] <= CNT_W'(WB_DEPTH);
        else if (!hold && (cnt[i] != '0))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign busy_rs = (cnt[rs] != '0);
  assign busy_rt = (cnt[rt] != '0);

  always_comb begin
    any_busy = 1'b0;
    for (int i = 1; i < NREG; i++) any_busy = any_busy | (cnt[i] != '0);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock / sequencing controller beside the ID stage of the 5-stage pipe.
// Stalls decode on RAW hazards seen in the scoreboard, squashes wrong-path
// work on a taken branch and freezes the back end while the MDU is busy.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   d_valid, d_rs, d_rt, d_use_rs,
//   d_use_rt, d_wr_en, d_wr_reg,
//   d_is_mdu                           decoded instruction currently in ID
//   ex_br_taken                        branch resolved taken in EX
//   mdu_done                           MDU result ready (one-cycle pulse)
//   stall_f, stall_d                   hold PC / IF/ID
//   bubble_ex, flush_d                 NOP into ID/EX / clear IF/ID
//   freeze                             hold ID/EX, EX/M, M/WB
//   sb_busy, state                     debug visibility
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int REGW     = 5,
  parameter int WB_DEPTH = 3,
  parameter int CNT_W    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            d_valid,
  input  logic [REGW-1:0] d_rs,
  input  logic [REGW-1:0] d_rt,
  input  logic            d_use_rs,
  input  logic            d_use_rt,
  input  logic            d_wr_en,
  input  logic [REGW-1:0] d_wr_reg,
  input  logic            d_is_mdu,
  input  logic            ex_br_taken,
  input  logic            mdu_done,
  output logic            stall_f,
  output logic            stall_d,
  output logic            bubble_ex,
  output logic            flush_d,
  output logic            freeze,
  output logic            sb_busy,
  output logic [1:0]      state
);

  state_t cur_state, next_state;
  logic   busy_rs, busy_rt;
  logic   raw, issue;

  reg_scoreboard #(
    .NREG(NREG), .REGW(REGW), .WB_DEPTH(WB_DEPTH), .CNT_W(CNT_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue),
    .issue_reg(d_wr_reg),
    .hold     (freeze),
    .rs       (d_rs),
    .rt       (d_rt),
    .busy_rs  (busy_rs),
    .busy_rt  (busy_rt),
    .any_busy (sb_busy)
  );

  // No forwarding: a register still in WB (count 1) is a hazard too.
  assign raw = d_valid & ((d_use_rs & (d_rs != '0) & busy_rs) |
                          (d_use_rt & (d_rt != '0) & busy_rt));

  assign issue = d_valid & ~stall_d & ~flush_d & d_wr_en & (d_wr_reg != '0);

  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred; combinational logic uses '='.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    bubble_ex  = 1'b0;
    flush_d    = 1'b0;
    freeze     = 1'b0;
    next_state = cur_state;
    // Outputs are forced low while reset is asserted, not just after it.
    if (rst_n) begin
      if (cur_state == ST_MDU_WAIT) begin
        // A taken branch cannot be in EX here: it sits behind the MDU op.
        if (mdu_done) begin
          next_state = ST_RUN;
        end else begin
          freeze  = 1'b1;
          stall_f = 1'b1;
          stall_d = 1'b1;
        end
      end else if (ex_br_taken) begin
        flush_d    = 1'b1;
        bubble_ex  = 1'b1;
        next_state = ST_REDIRECT;
      end else if (cur_state == ST_REDIRECT) begin
        // Refetch slot is still empty; ID gets cleared rather than stalled.
        flush_d    = 1'b1;
        bubble_ex  = 1'b1;
        next_state = raw ? ST_RAW_STALL : ST_RUN;
      end else if (raw) begin
        stall_f    = 1'b1;
        stall_d    = 1'b1;
        bubble_ex  = 1'b1;
        next_state = ST_RAW_STALL;
      end else begin
        // The instruction leaves ID now; an MDU op then freezes the back end,
        // whether or not it writes a GPR and whether it came from a stall.
        next_state = (d_valid && d_is_mdu) ? ST_MDU_WAIT : ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_RUN;
    else        cur_state <= next_state;
  end

  assign state = cur_state;

endmodule
